// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the tamagotchi blocks: care-action indices, action
// count, the care-action FSM state type and a counter-width helper.
package tamagotchi_pkg;

    localparam int ACT_HUNGER  = 0;
    localparam int ACT_HAPPY   = 1;
    localparam int ACT_HEALTH  = 2;
    localparam int ACT_HYGIENE = 3;
    localparam int ACT_ENERGY  = 4;
    localparam int ACT_SOCIAL  = 5;

    localparam int NUM_ACTIONS = 6;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        COOLDOWN
    } state_t;

    // A counter that must hold n-1 needs $clog2(n) bits, but never fewer than one.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/care_action_ctrl_if.sv
// Button pins in, care-action vector and status out. The master side is the
// board / button source; the slave side is care_action_ctrl.
interface care_action_ctrl_if;

    logic       btn_next;
    logic       btn_prev;
    logic       btn_ok;
    logic [7:0] action;
    logic [2:0] sel;
    logic       busy;
    logic       reject;

    modport master (
        output btn_next, btn_prev, btn_ok,
        input  action, sel, busy, reject
    );

    modport slave (
        input  btn_next, btn_prev, btn_ok,
        output action, sel, busy, reject
    );

endinterface

// File: rtl/care_action_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for a raw button pin, followed by a rising-edge
// detector that emits a one-cycle pulse on each 0->1 transition.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic meta;
    logic synced;
    logic synced_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= 1'b0;
            synced   <= 1'b0;
            synced_q <= 1'b0;
        end else begin
            meta     <= btn;
            synced   <= meta;
            synced_q <= synced;
        end
    end

    assign rise = synced & ~synced_q;

endmodule

// File: rtl/care_action_ctrl.sv
// Menu cursor over the care actions; on confirm drives one action bit for DOSE
// cycles, then locks out further confirms for COOLDOWN_CYCLES cycles.
module care_action_ctrl
    import tamagotchi_pkg::*;
#(
    parameter int NUM_ACTIONS     = tamagotchi_pkg::NUM_ACTIONS,
    parameter int DOSE            = 1,
    parameter int COOLDOWN_CYCLES = 27_000_000
) (
    input logic                clk,
    input logic                rst,
    care_action_ctrl_if.slave  bus
);

    localparam int         DOSE_W   = cnt_width(DOSE);
    localparam int         CD_W     = cnt_width(COOLDOWN_CYCLES);
    localparam logic [2:0] SEL_LAST = 3'(NUM_ACTIONS - 1);

    logic next_rise;
    logic prev_rise;
    logic ok_rise;

    btn_sync_edge u_next (.clk(clk), .rst(rst), .btn(bus.btn_next), .rise(next_rise));
    btn_sync_edge u_prev (.clk(clk), .rst(rst), .btn(bus.btn_prev), .rise(prev_rise));
    btn_sync_edge u_ok   (.clk(clk), .rst(rst), .btn(bus.btn_ok),   .rise(ok_rise));

    state_t            state;
    logic [2:0]        sel_q;
    logic [2:0]        sel_d;
    logic [2:0]        dose_idx;
    logic [DOSE_W-1:0] dose_cnt;
    logic [CD_W-1:0]   cd_cnt;
    logic [7:0]        action_q;
    logic              busy_q;
    logic              reject_q;
    logic              fire_now;

    assign fire_now = (state == IDLE) && ok_rise;

    // An accepted confirm freezes the cursor so the fired index is the pre-move one.
    always_comb begin
        // NOTE: default first so every path assigns sel_d and no latch is inferred.
        sel_d = sel_q;
        if (!fire_now) begin
            if (next_rise && !prev_rise) begin
                sel_d = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
            end else if (prev_rise && !next_rise) begin
                sel_d = (sel_q == 3'd0) ? SEL_LAST : sel_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel_q    <= '0;
            dose_idx <= '0;
            dose_cnt <= '0;
            cd_cnt   <= '0;
            action_q <= '0;
            busy_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            reject_q <= ok_rise && (state != IDLE);
            case (state)
                IDLE: begin
                    if (ok_rise) begin
                        dose_idx <= sel_q;
                        dose_cnt <= DOSE_W'(DOSE - 1);
                        action_q <= 8'd1 << sel_q;
                        busy_q   <= 1'b1;
                        state    <= FIRE;
                    end
                end
                FIRE: begin
                    if (dose_cnt != '0) begin
                        dose_cnt <= dose_cnt - 1'b1;
                        action_q <= 8'd1 << dose_idx;
                    end else begin
                        action_q <= '0;
                        cd_cnt   <= CD_W'(COOLDOWN_CYCLES - 1);
                        state    <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt != '0) begin
                        cd_cnt <= cd_cnt - 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    action_q <= '0;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.action = action_q;
    assign bus.sel    = sel_q;
    assign bus.busy   = busy_q;
    assign bus.reject = reject_q;

endmodule

// File: tb/tb_care_action_ctrl.sv
// Directed bench for care_action_ctrl with DOSE=2, COOLDOWN_CYCLES=8; all
// expected values are hand-computed constants.
module tb_care_action_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    care_action_ctrl_if bus ();

    care_action_ctrl #(
        .DOSE            (2),
        .COOLDOWN_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int         act_first;
    int         act_cnt;
    logic [7:0] act_or;
    int         busy_first;
    int         busy_cnt;
    int         rej_first;
    int         rej_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pins(input logic nx, input logic pv, input logic ok);
        bus.btn_next = nx;
        bus.btn_prev = pv;
        bus.btn_ok   = ok;
    endtask

    // Drive pins at a falling edge, release after `hold` samples, optionally
    // raise ok again after sample ok2_at, and record output activity.
    // Sample i is taken on the falling edge after rising edge N+i-1.
    task automatic watch(input logic nx, input logic pv, input logic ok,
                         input int hold, input int ok2_at, input int n);
        act_first  = 0; act_cnt  = 0; act_or = '0;
        busy_first = 0; busy_cnt = 0;
        rej_first  = 0; rej_cnt  = 0;
        pins(nx, pv, ok);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (bus.action != 8'd0) begin
                if (act_first == 0) act_first = i;
                act_cnt++;
                act_or |= bus.action;
            end
            if (bus.busy) begin
                if (busy_first == 0) busy_first = i;
                busy_cnt++;
            end
            if (bus.reject) begin
                if (rej_first == 0) rej_first = i;
                rej_cnt++;
            end
            if (i == hold) pins(1'b0, 1'b0, 1'b0);
            if (ok2_at != 0 && i == ok2_at) bus.btn_ok = 1'b1;
            if (ok2_at != 0 && i == ok2_at + hold) bus.btn_ok = 1'b0;
        end
        pins(1'b0, 1'b0, 1'b0);
    endtask

    task automatic step(input logic nx, input logic pv, input logic [2:0] exp_sel, input string tag);
        watch(nx, pv, 1'b0, 2, 0, 5);
        check(tag, 32'(bus.sel), 32'(exp_sel));
    endtask

    initial begin
        rst = 1'b1;
        pins(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_action", 32'(bus.action), 32'h0);
        check("rst_sel",    32'(bus.sel),    32'h0);
        check("rst_busy",   32'(bus.busy),   32'h0);
        check("rst_reject", 32'(bus.reject), 32'h0);
        repeat (2) @(negedge clk);

        // Single confirm at cursor 0.
        watch(1'b0, 1'b0, 1'b1, 2, 0, 16);
        check("ok1_act_first",  32'(act_first),  32'd3);
        check("ok1_act_cnt",    32'(act_cnt),    32'd2);
        check("ok1_act_val",    32'(act_or),     32'h01);
        check("ok1_busy_first", 32'(busy_first), 32'd3);
        check("ok1_busy_cnt",   32'(busy_cnt),   32'd10);
        check("ok1_reject",     32'(rej_cnt),    32'd0);
        check("ok1_sel",        32'(bus.sel),    32'd0);

        // Cursor walk forward with wrap, then backward with wrap.
        step(1'b1, 1'b0, 3'd1, "next_1");
        step(1'b1, 1'b0, 3'd2, "next_2");
        step(1'b1, 1'b0, 3'd3, "next_3");
        step(1'b1, 1'b0, 3'd4, "next_4");
        step(1'b1, 1'b0, 3'd5, "next_5");
        step(1'b1, 1'b0, 3'd0, "next_wrap");
        step(1'b1, 1'b0, 3'd1, "next_7");
        step(1'b0, 1'b1, 3'd0, "prev_1");
        step(1'b0, 1'b1, 3'd5, "prev_wrap");
        watch(1'b0, 1'b0, 1'b1, 2, 0, 16);
        check("ok5_act_val", 32'(act_or),  32'h20);
        check("ok5_act_cnt", 32'(act_cnt), 32'd2);

        // Second ok four cycles after the first lands in COOLDOWN.
        watch(1'b0, 1'b0, 1'b1, 2, 4, 18);
        check("dbl_reject_cnt", 32'(rej_cnt),    32'd1);
        check("dbl_reject_at",  32'(rej_first),  32'd7);
        check("dbl_act_cnt",    32'(act_cnt),    32'd2);
        check("dbl_busy_first", 32'(busy_first), 32'd3);
        check("dbl_busy_cnt",   32'(busy_cnt),   32'd10);

        // Cursor to 2, then next and ok together: ok wins with the old index.
        step(1'b1, 1'b0, 3'd0, "to2_a");
        step(1'b1, 1'b0, 3'd1, "to2_b");
        step(1'b1, 1'b0, 3'd2, "to2_c");
        watch(1'b1, 1'b0, 1'b1, 2, 0, 16);
        check("nxok_act_val", 32'(act_or),  32'h04);
        check("nxok_sel",     32'(bus.sel), 32'd2);
        step(1'b1, 1'b0, 3'd3, "nxok_then_next");
        step(1'b1, 1'b1, 3'd3, "next_prev_same");

        // Held ok: one edge, one dose, nothing refused.
        watch(1'b0, 1'b0, 1'b1, 30, 0, 34);
        check("hold_act_cnt", 32'(act_cnt), 32'd2);
        check("hold_act_val", 32'(act_or),  32'h08);
        check("hold_reject",  32'(rej_cnt), 32'd0);

        // Reset in the second FIRE cycle.
        pins(1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("rf_fire1", 32'(bus.action), 32'h08);
        @(negedge clk);
        check("rf_fire2", 32'(bus.action), 32'h08);
        rst = 1'b1;
        #1;
        check("rf_action", 32'(bus.action), 32'h0);
        check("rf_sel",    32'(bus.sel),    32'h0);
        check("rf_busy",   32'(bus.busy),   32'h0);
        pins(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        watch(1'b0, 1'b0, 1'b1, 2, 0, 16);
        check("post_act_first", 32'(act_first), 32'd3);
        check("post_act_cnt",   32'(act_cnt),   32'd2);
        check("post_act_val",   32'(act_or),    32'h01);
        check("post_busy_cnt",  32'(busy_cnt),  32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/care_action_ctrl.md
# care_action_ctrl

Player-side producer of the 8-bit care-action vector consumed by the stats block, whose `inputs[k]` decrements stat k by 1 per cycle while held high. The block turns three raw push-buttons into a menu cursor over the six care actions: feed, play, heal, wash, rest and socialize. On confirm it drives the selected `action` bit high for exactly DOSE cycles, then enforces a cooldown before another action is accepted. It sits between the board button pins and the stats block's `inputs` port.

## Interface
Parameters:
- NUM_ACTIONS, 6: number of selectable actions; cursor range 0..NUM_ACTIONS-1.
- DOSE, 1: cycles the selected action bit is held high per confirm (1..15), i.e. stat decrement per confirm.
- COOLDOWN_CYCLES, 27_000_000: lockout length after a dose (1 s at 27 MHz); must be ≥1.

Ports:
- clk  in  1  27 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_next  in  1  raw button, asynchronous to clk; advance cursor.
- btn_prev  in  1  raw button, asynchronous to clk; move cursor back.
- btn_ok  in  1  raw button, asynchronous to clk; confirm the selected action.
- action  out  8  one-hot action vector to stats `inputs`; bits 6..7 are always 0.
- sel  out  3  current cursor index, for the display.
- busy  out  1  high during FIRE and COOLDOWN.
- reject  out  1  one-cycle pulse when an ok press is refused.

## Operation
- Each button passes through a 2-flop synchronizer and a rising-edge detector. Only a 0→1 transition counts; held levels do nothing.
- FSM states and transitions:
  - IDLE → FIRE on ok edge. Latch `sel` into the dose index, load the dose counter with DOSE-1, and set `action[sel]`.
  - FIRE: hold `action[idx]` while the dose counter >0, decrementing it each cycle. When it reaches 0, clear `action`, load the cooldown counter with COOLDOWN_CYCLES-1, and go to COOLDOWN.
  - COOLDOWN: decrement the counter each cycle; go to IDLE on the cycle after it reaches 0.
- Cursor:
  - next: sel+1, wrapping from NUM_ACTIONS-1 to 0.
  - prev: sel-1, wrapping from 0 to NUM_ACTIONS-1.
  - next and prev edges in the same cycle: no move.
  - The cursor moves in all states. The dose index stays latched, so moving during FIRE does not change the bit being driven.
- ok edge with next/prev edge in the same cycle while IDLE: ok wins and fires the pre-move index; the cursor does not move that cycle.
- ok edge in FIRE or COOLDOWN: `reject`=1 for one cycle; state and counters are unchanged.
- `action` always has at most one bit set.
- Reset values: action=0, sel=0, busy=0, reject=0, state IDLE, all synchronizer/edge flops 0, counters 0. Reset mid-FIRE clears `action` asynchronously.

## Timing
- Button-to-effect latency: a pin rising before clk edge N produces its effect (action asserted, cursor moved or reject pulse) after edge N+2.
- `action` is high for exactly DOSE consecutive cycles. `busy` rises with `action` and stays high for DOSE+COOLDOWN_CYCLES cycles.
- Earliest next accepted ok: the edge detected in the first IDLE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared `tamagotchi_pkg` holds:
  - action index constants: ACT_HUNGER=0, ACT_HAPPY=1, ACT_HEALTH=2, ACT_HYGIENE=3, ACT_ENERGY=4, ACT_SOCIAL=5;
  - NUM_ACTIONS;
  - the FSM state enum {IDLE, FIRE, COOLDOWN}.
- One sub-module, `btn_sync_edge`: a 2-flop synchronizer plus a registered-previous flop, producing a one-cycle rise pulse. It is instantiated three times.
- Counter widths are sized by $clog2 of DOSE and of COOLDOWN_CYCLES.

## Test plan
Bench parameters: DOSE=2, COOLDOWN_CYCLES=8.
- Reset, then ok press → action=0x01 for exactly 2 cycles, 3 cycles after the press; busy high for 10 cycles; sel=0.
- Press next 7 times → sel steps 1,2,3,4,5,0,1. Then prev twice → sel 0, then 5; ok → action=0x20.
- ok, then a second ok 4 cycles later → one reject pulse; no second dose; busy timing unchanged.
- Cursor at 2: next and ok edges in the same cycle → action=0x04, and sel moves on the next press only. next and prev in the same cycle → sel unchanged.
- Hold ok high for 30 cycles → exactly one dose and no reject.
- Assert rst during the second cycle of FIRE → action=0 immediately, sel=0, busy=0; a post-reset ok fires normally.
